// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multicycle MIPS sequencer and its datapath.
// Carries the opcode and memory-ready inputs plus every datapath control
// strobe the sequencer drives.
//   master : the sequencer side (drives o_*, reads i_*)
//   slave  : the datapath side (drives i_*, reads o_*)
// With MIPS_MC_BNE_EN defined, the bus also carries o_branchNe.
interface mips_multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 2
);
    logic [OPCODE_W-1:0] i_instrCode;
    logic                i_memReady;
    logic                o_memReq;
    logic                o_iord;
    logic                o_memWrite;
    logic                o_irWrite;
    logic                o_pcWrite;
    logic                o_pcWriteCond;
    logic [1:0]          o_pcSrc;
    logic                o_regDst;
    logic                o_memToReg;
    logic                o_regWrite;
    logic                o_aluSrcA;
    logic [1:0]          o_aluSrcB;
    logic [ALUOP_W-1:0]  o_aluOp;
    logic                o_extOp;
    logic                o_illegal;
    logic                o_memErr;
    logic [3:0]          o_state;
`ifdef MIPS_MC_BNE_EN
    logic                o_branchNe;
`endif

    modport master (
        input  i_instrCode, i_memReady,
`ifdef MIPS_MC_BNE_EN
        output o_branchNe,
`endif
        output o_memReq, o_iord, o_memWrite, o_irWrite, o_pcWrite,
               o_pcWriteCond, o_pcSrc, o_regDst, o_memToReg, o_regWrite,
               o_aluSrcA, o_aluSrcB, o_aluOp, o_extOp, o_illegal,
               o_memErr, o_state
    );

    modport slave (
        output i_instrCode, i_memReady,
`ifdef MIPS_MC_BNE_EN
        input  o_branchNe,
`endif
        input  o_memReq, o_iord, o_memWrite, o_irWrite, o_pcWrite,
               o_pcWriteCond, o_pcSrc, o_regDst, o_memToReg, o_regWrite,
               o_aluSrcA, o_aluSrcB, o_aluOp, o_extOp, o_illegal,
               o_memErr, o_state
    );
endinterface

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control sequencer. A state machine walks each instruction
// through fetch, decode, execute, memory and writeback, driving a
// shared-memory datapath and waiting on a memory ready handshake.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : mips_multicycle_control_if.master (opcode, memReady, control strobes)
// Optional feature macro MIPS_MC_BNE_EN: decodes bne (000101) to BRANCH and
// drives bus.o_branchNe; without it 000101 is an illegal opcode.
// MEM_TIMEOUT > 0 enables a watchdog that aborts a stalled memory access.
module mips_multicycle_control #(
    parameter int OPCODE_W    = 6,
    parameter int ALUOP_W     = 2,
    parameter int MEM_TIMEOUT = 0,
    parameter int TMO_W       = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    mips_multicycle_control_if.master   bus
);
    typedef enum logic [3:0] {
        IDLE   = 4'd0,  FETCH  = 4'd1,  DECODE = 4'd2,  MEMADR = 4'd3,
        MEMRD  = 4'd4,  MEMWB  = 4'd5,  MEMWR  = 4'd6,  EXEC   = 4'd7,
        ALUWB  = 4'd8,  BRANCH = 4'd9,  JUMP   = 4'd10, IMMEX  = 4'd11,
        IMMWB  = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(0);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2);

    state_t             state, state_nxt;
    logic [5:0]         op_q;
    logic [5:0]         op_in;
    logic               hi_zero;
    logic               mem_wait;
    logic               tmo_hit;

    logic               mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond;
    logic [1:0]         pc_src, alu_src_b;
    logic               reg_dst, mem_to_reg, reg_write, alu_src_a, ext_op;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal, mem_err, branch_ne;

    assign op_in = bus.i_instrCode[5:0];

    // Opcode bits above the 6-bit field must be zero for a legal decode.
    generate
        if (OPCODE_W > 6) begin : g_hi
            assign hi_zero = (bus.i_instrCode[OPCODE_W-1:6] == '0);
        end else begin : g_no_hi
            assign hi_zero = 1'b1;
        end
    endgenerate

    assign mem_wait = ((state == FETCH) || (state == MEMRD) || (state == MEMWR))
                      && !bus.i_memReady;

    // Watchdog: counts stalled cycles of the current access; a ready in the
    // same cycle the limit is reached clears mem_wait, so ready wins.
    generate
        if (MEM_TIMEOUT > 0) begin : g_tmo
            logic [TMO_W-1:0] tmo_cnt;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n)
                    tmo_cnt <= '0;
                else if (mem_wait && !tmo_hit)
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                else
                    tmo_cnt <= '0;
            end
            assign tmo_hit = mem_wait && (tmo_cnt == TMO_W'(MEM_TIMEOUT));
        end else begin : g_no_tmo
            assign tmo_hit = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
            op_q  <= '0;
        end else begin
            state <= state_nxt;
            if (state == DECODE)
                op_q <= op_in;
        end
    end

    // Next state and control decode. The strobes are functions of the state
    // register; the only input qualifiers are memReady on the FETCH writes
    // and the illegal/timeout pulses, which exist to mark a single cycle.
    always_comb begin
        state_nxt     = state;
        mem_req       = 1'b0;
        iord          = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        pc_src        = 2'd0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'd0;
        alu_op        = ALU_ADD;
        ext_op        = 1'b0;
        illegal       = 1'b0;
        mem_err       = tmo_hit;
        branch_ne     = 1'b0;
        case (state)
            IDLE: state_nxt = FETCH;
            FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'd1;
                ir_write  = bus.i_memReady;
                pc_write  = bus.i_memReady;
                if (bus.i_memReady) state_nxt = DECODE;
                else if (tmo_hit)   state_nxt = FETCH;
            end
            DECODE: begin
                alu_src_b = 2'd3;
                ext_op    = 1'b1;
                state_nxt = FETCH;
                if (hi_zero) begin
                    case (op_in)
                        OP_RTYPE:          state_nxt = EXEC;
                        OP_LW, OP_SW:      state_nxt = MEMADR;
                        OP_BEQ:            state_nxt = BRANCH;
`ifdef MIPS_MC_BNE_EN
                        OP_BNE:            state_nxt = BRANCH;
`endif
                        OP_J:              state_nxt = JUMP;
                        OP_ADDI, OP_ADDIU: state_nxt = IMMEX;
                        default:           illegal   = 1'b1;
                    endcase
                end else begin
                    illegal = 1'b1;
                end
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = 1'b1;
                state_nxt = (op_q == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (bus.i_memReady) state_nxt = MEMWB;
                else if (tmo_hit)   state_nxt = FETCH;
            end
            MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_nxt  = FETCH;
            end
            MEMWR: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.i_memReady || tmo_hit) state_nxt = FETCH;
            end
            EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_nxt = FETCH;
            end
            BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = 2'd1;
                branch_ne     = (op_q == OP_BNE);
                state_nxt     = FETCH;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pc_src    = 2'd2;
                state_nxt = FETCH;
            end
            IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
                ext_op    = (op_q == OP_ADDI);
                state_nxt = IMMWB;
            end
            IMMWB: begin
                reg_write = 1'b1;
                state_nxt = FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.o_memReq      = mem_req;
    assign bus.o_iord        = iord;
    assign bus.o_memWrite    = mem_write;
    assign bus.o_irWrite     = ir_write;
    assign bus.o_pcWrite     = pc_write;
    assign bus.o_pcWriteCond = pc_write_cond;
    assign bus.o_pcSrc       = pc_src;
    assign bus.o_regDst      = reg_dst;
    assign bus.o_memToReg    = mem_to_reg;
    assign bus.o_regWrite    = reg_write;
    assign bus.o_aluSrcA     = alu_src_a;
    assign bus.o_aluSrcB     = alu_src_b;
    assign bus.o_aluOp       = alu_op;
    assign bus.o_extOp       = ext_op;
    assign bus.o_illegal     = illegal;
    assign bus.o_memErr      = mem_err;
    assign bus.o_state       = state;
`ifdef MIPS_MC_BNE_EN
    assign bus.o_branchNe    = branch_ne;
`else
    logic unused_bne;
    assign unused_bne = branch_ne;
`endif
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control. Expected per-cycle
// behaviour comes from a sequence model that lists, for each instruction,
// the states it visits under given memory wait counts.
`timescale 1ns/1ps
module tb_mips_multicycle_control;
    localparam int TMO = 4;
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMRD = 4,
                   S_MEMWB = 5, S_MEMWR = 6, S_EXEC = 7, S_ALUWB = 8, S_BRANCH = 9,
                   S_JUMP = 10, S_IMMEX = 11, S_IMMWB = 12;
    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                           OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_J = 6'b000010,
                           OP_ADDI = 6'b001000, OP_ADDIU = 6'b001001;

    typedef struct packed {
        logic [3:0] st;
        logic       req, iord, mw, irw, pcw, pcwc;
        logic [1:0] pcsrc;
        logic       regdst, m2r, rw, srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic       ext, ill, err;
`ifdef MIPS_MC_BNE_EN
        logic       bne;
`endif
    } ctrl_t;

    typedef struct {
        int         st;
        bit         rdy;
        bit         err;
        bit         ill;
        logic [5:0] op;
        logic [5:0] drv;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    ent_t seq[$];

    mips_multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) bus();

    mips_multicycle_control #(
        .OPCODE_W(6), .ALUOP_W(2), .MEM_TIMEOUT(TMO), .TMO_W(8)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    function automatic ctrl_t observe();
        ctrl_t c;
        c.st = bus.o_state;      c.req = bus.o_memReq;     c.iord = bus.o_iord;
        c.mw = bus.o_memWrite;   c.irw = bus.o_irWrite;    c.pcw = bus.o_pcWrite;
        c.pcwc = bus.o_pcWriteCond; c.pcsrc = bus.o_pcSrc; c.regdst = bus.o_regDst;
        c.m2r = bus.o_memToReg;  c.rw = bus.o_regWrite;    c.srca = bus.o_aluSrcA;
        c.srcb = bus.o_aluSrcB;  c.aluop = bus.o_aluOp;    c.ext = bus.o_extOp;
        c.ill = bus.o_illegal;   c.err = bus.o_memErr;
`ifdef MIPS_MC_BNE_EN
        c.bne = bus.o_branchNe;
`endif
        return c;
    endfunction

    // Control table: what each state is supposed to assert.
    function automatic ctrl_t exp_outs(ent_t e);
        ctrl_t c = '0;
        c.st = 4'(e.st);
        case (e.st)
            S_FETCH:  begin c.req = 1; c.srcb = 2'd1; c.irw = e.rdy; c.pcw = e.rdy; end
            S_DECODE: begin c.srcb = 2'd3; c.ext = 1; end
            S_MEMADR: begin c.srca = 1; c.srcb = 2'd2; c.ext = 1; end
            S_MEMRD:  begin c.req = 1; c.iord = 1; end
            S_MEMWB:  begin c.rw = 1; c.m2r = 1; end
            S_MEMWR:  begin c.req = 1; c.mw = 1; c.iord = 1; end
            S_EXEC:   begin c.srca = 1; c.aluop = 2'd2; end
            S_ALUWB:  begin c.rw = 1; c.regdst = 1; end
            S_BRANCH: begin c.srca = 1; c.aluop = 2'd1; c.pcwc = 1; c.pcsrc = 2'd1; end
            S_JUMP:   begin c.pcw = 1; c.pcsrc = 2'd2; end
            S_IMMEX:  begin c.srca = 1; c.srcb = 2'd2; c.ext = (e.op == OP_ADDI); end
            S_IMMWB:  begin c.rw = 1; end
            default:  ;
        endcase
        c.err = e.err;
        c.ill = e.ill;
`ifdef MIPS_MC_BNE_EN
        c.bne = (e.st == S_BRANCH) && (e.op == OP_BNE);
`endif
        return c;
    endfunction

    function automatic bit is_legal(logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU: return 1'b1;
`ifdef MIPS_MC_BNE_EN
            OP_BNE: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // The opcode is only presented during DECODE; elsewhere the input
    // carries junk so a design that rereads it goes wrong.
    task automatic push(input int st, input bit rdy, input bit err, input bit ill,
                        input logic [5:0] op);
        ent_t e;
        e.st = st; e.rdy = rdy; e.err = err; e.ill = ill; e.op = op;
        e.drv = (st == S_DECODE) ? op : 6'($urandom);
        seq.push_back(e);
    endtask

    // A memory access stalled for 'waits' cycles: completes if the watchdog
    // limit is not exceeded, otherwise aborts on the stalled cycle after
    // TMO stalled cycles have already been counted.
    task automatic push_mem(input int st, input int waits, input logic [5:0] op,
                            output bit to);
        if (waits > TMO) begin
            for (int k = 0; k < TMO; k++) push(st, 1'b0, 1'b0, 1'b0, op);
            push(st, 1'b0, 1'b1, 1'b0, op);
            to = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) push(st, 1'b0, 1'b0, 1'b0, op);
            push(st, 1'b1, 1'b0, 1'b0, op);
            to = 1'b0;
        end
    endtask

    task automatic build_seq(input logic [5:0] op, input int wf, input int wm);
        bit to;
        bit legal;
        seq.delete();
        push_mem(S_FETCH, wf, op, to);
        if (to) push_mem(S_FETCH, 0, op, to);
        legal = is_legal(op);
        push(S_DECODE, 1'($urandom), 1'b0, !legal, op);
        if (legal) begin
            case (op)
                OP_RTYPE: begin
                    push(S_EXEC, 1'($urandom), 0, 0, op);
                    push(S_ALUWB, 1'($urandom), 0, 0, op);
                end
                OP_LW: begin
                    push(S_MEMADR, 1'($urandom), 0, 0, op);
                    push_mem(S_MEMRD, wm, op, to);
                    if (!to) push(S_MEMWB, 1'($urandom), 0, 0, op);
                end
                OP_SW: begin
                    push(S_MEMADR, 1'($urandom), 0, 0, op);
                    push_mem(S_MEMWR, wm, op, to);
                end
                OP_J: push(S_JUMP, 1'($urandom), 0, 0, op);
                OP_ADDI, OP_ADDIU: begin
                    push(S_IMMEX, 1'($urandom), 0, 0, op);
                    push(S_IMMWB, 1'($urandom), 0, 0, op);
                end
                default: push(S_BRANCH, 1'($urandom), 0, 0, op);
            endcase
        end
    endtask

    task automatic step(input ent_t e, output ctrl_t obs);
        @(negedge clk);
        bus.i_memReady  = e.rdy;
        bus.i_instrCode = e.drv;
        #1 obs = observe();
    endtask

    task automatic test_reset();
        ctrl_t obs;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.i_memReady  = 1'($urandom);
            bus.i_instrCode = 6'($urandom);
            #1 obs = observe();
            checks++;
            if (obs !== ctrl_t'('0)) begin
                failures++;
                $display("FAIL reset_hold cyc%0d observed=%h expected=%h", k, obs, ctrl_t'('0));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1 obs = observe();
        checks++;
        if (obs !== ctrl_t'('0)) begin
            failures++;
            $display("FAIL reset_release_idle observed=%h expected=%h", obs, ctrl_t'('0));
        end
    endtask

    task automatic test_rtype();
        ctrl_t obs, exp;
        build_seq(OP_RTYPE, 0, 0);
        foreach (seq[i]) begin
            step(seq[i], obs);
            exp = exp_outs(seq[i]);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL rtype cyc%0d observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_lw();
        ctrl_t obs, exp;
        build_seq(OP_LW, 0, 3);
        foreach (seq[i]) begin
            step(seq[i], obs);
            exp = exp_outs(seq[i]);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL lw_wait3 cyc%0d observed=%h expected=%h", i, obs, exp);
            end
        end
    endtask

    task automatic test_timeout();
        ctrl_t obs, exp;
        logic [5:0] ops[4] = '{OP_LW, OP_SW, OP_LW, OP_J};
        int wfs[4] = '{5, 0, 0, 4};
        int wms[4] = '{0, 6, 4, 0};
        for (int t = 0; t < 4; t++) begin
            build_seq(ops[t], wfs[t], wms[t]);
            foreach (seq[i]) begin
                step(seq[i], obs);
                exp = exp_outs(seq[i]);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL timeout%0d cyc%0d observed=%h expected=%h", t, i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_illegal();
        ctrl_t obs, exp;
        logic [5:0] ops[3] = '{6'b111111, OP_BNE, 6'b010000};
        for (int t = 0; t < 3; t++) begin
            build_seq(ops[t], 1, 0);
            foreach (seq[i]) begin
                step(seq[i], obs);
                exp = exp_outs(seq[i]);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL illegal_%b cyc%0d observed=%h expected=%h", ops[t], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_imm_branch();
        ctrl_t obs, exp;
        logic [5:0] ops[6] = '{OP_ADDIU, OP_ADDI, OP_BEQ, OP_J, OP_SW, OP_BNE};
        for (int t = 0; t < 6; t++) begin
            build_seq(ops[t], 0, 1);
            foreach (seq[i]) begin
                step(seq[i], obs);
                exp = exp_outs(seq[i]);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL instr_%b cyc%0d observed=%h expected=%h", ops[t], i, obs, exp);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        ctrl_t obs, exp;
        build_seq(OP_SW, 0, 3);
        for (int i = 0; i < 4; i++) begin
            step(seq[i], obs);
            exp = exp_outs(seq[i]);
            checks++;
            if (obs !== exp) begin
                failures++;
                $display("FAIL reset_mid_pre cyc%0d observed=%h expected=%h", i, obs, exp);
            end
        end
        #2 rst_n = 1'b0;
        #1 obs = observe();
        checks++;
        if (obs !== ctrl_t'('0)) begin
            failures++;
            $display("FAIL reset_mid_async observed=%h expected=%h", obs, ctrl_t'('0));
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.i_memReady = 1'b1;
        #1 obs = observe();
        checks++;
        if (obs !== ctrl_t'('0)) begin
            failures++;
            $display("FAIL reset_mid_idle observed=%h expected=%h", obs, ctrl_t'('0));
        end
    endtask

    task automatic test_random();
        ctrl_t obs, exp;
        logic [5:0] pool[8] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ADDIU, OP_BNE};
        logic [5:0] op;
        for (int n = 0; n < 60; n++) begin
            op = ($urandom_range(0, 9) > 7) ? 6'($urandom) : pool[$urandom_range(0, 7)];
            build_seq(op, $urandom_range(0, 6), $urandom_range(0, 6));
            foreach (seq[i]) begin
                step(seq[i], obs);
                exp = exp_outs(seq[i]);
                checks++;
                if (obs !== exp) begin
                    failures++;
                    $display("FAIL random n%0d op=%b cyc%0d observed=%h expected=%h",
                             n, op, i, obs, exp);
                end
            end
        end
    endtask

    initial begin
        bus.i_memReady  = 1'b0;
        bus.i_instrCode = '0;
        test_reset();
        test_rtype();
        test_lw();
        test_timeout();
        test_illegal();
        test_imm_branch();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
